// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and the output consumer.
// The arbiter takes the slave side; the requester/consumer environment takes the master side.
interface mux_rr_arbiter_if #(
  parameter int DW = 1
);
  logic [7:0]         req;
  logic [7:0][DW-1:0] data;
  logic               out_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [2:0]         out_src;
  logic [2:0]         sel;
  logic [7:0]         gnt;
  logic               busy;

  modport slave (
    input  req, data, out_ready,
    output out_valid, out_data, out_src, sel, gnt, busy
  );

  modport master (
    output req, data, out_ready,
    input  out_valid, out_data, out_src, sel, gnt, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// 8-lane round-robin arbiter driving the 8:1 mux select, with bounded bursts per grant
// and a valid/ready output that forwards the granted lane's data.
module mux_rr_lane #(
  parameter int          DW  = 1,
  parameter logic [2:0]  IDX = 3'd0
) (
  input  logic [2:0]    sel_i,
  input  logic          vld_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  assign q_o = (vld_i && (sel_i == IDX)) ? d_i : '0;
endmodule

module mux_rr_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mux_rr_arbiter_if.slave   bus
);
  localparam int NUM_LANES = 8;
  localparam int CW        = $clog2(MAX_HOLD) + 1;

  typedef enum logic { S_IDLE, S_GRANT } state_e;

  state_e        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          cur_req, xfer, rel;
  logic [2:0]    start;
  logic          found;
  logic [2:0]    winner;
  logic [NUM_LANES-1:0][DW-1:0] lane_q;

  // First set bit of r at or after start, wrapping 7 -> 0; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] s);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = s + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign cur_req = bus.req[sel_q];
  assign xfer    = (state_q == S_GRANT) && cur_req && bus.out_ready;
  assign rel     = (state_q == S_GRANT) &&
                   (!cur_req || (xfer && (cnt_q == CW'(MAX_HOLD - 1))));
  assign start   = (state_q == S_IDLE) ? ptr_q : sel_q + 3'd1;
  assign {found, winner} = rr_pick(bus.req, start);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          sel_d   = winner;
          gnt_d   = 8'b1 << winner;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (rel) begin
          // Released lane sits last in the search order but may win again.
          ptr_d = sel_q + 3'd1;
          if (found) begin
            sel_d = winner;
            gnt_d = 8'b1 << winner;
            cnt_d = '0;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy      = (state_q == S_GRANT);
  assign bus.out_valid = bus.busy && cur_req;
  assign bus.sel       = sel_q;
  assign bus.out_src   = sel_q;
  assign bus.gnt       = gnt_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mux_rr_lane #(.DW(DW), .IDX(3'(g))) u_lane (
      .sel_i (sel_q),
      .vld_i (bus.out_valid),
      .d_i   (bus.data[g]),
      .q_o   (lane_q[g])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < NUM_LANES; i++) bus.out_data |= lane_q[i];
  end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the 8:1 multiplexer datapath. Eight requesters share one output channel. The block arbitrates among their request lines, drives the mux select, and forwards the selected input to a valid/ready output. Grants are held for a bounded burst, then rotated, so no requester can starve another. It sits directly in front of the 8:1 mux and owns its `sel` input; the consumer sits on the output handshake.

## Interface
- `DW`, default 1: data width per input lane.
- `MAX_HOLD`, default 4: maximum transfers per grant. Legal range 1..15.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: request per requester; bit i belongs to lane i.
- `in`  in  8*DW: lane data; lane i is `in[i*DW +: DW]`.
- `out_ready`  in  1: consumer accepts data this cycle.
- `out_valid`  out  1: output data valid.
- `out_data`  out  DW: selected lane data.
- `out_src`  out  3: index of the granted lane; equals `sel`.
- `sel`  out  3: mux select, registered.
- `gnt`  out  8: one-hot grant, registered; all zeros when idle.
- `busy`  out  1: high while in GRANT.

## Operation
- FSM has two states: IDLE and GRANT.
- Registered state:
  - `ptr` (3 bits): next highest-priority lane.
  - `sel`, `gnt`.
  - `cnt`: transfer counter, width clog2(MAX_HOLD)+1.
- Arbitration: search `req` starting at lane `ptr`, ascending with wrap-around 7 to 0. The first set bit wins.
- IDLE:
  - If `req` == 0, stay in IDLE.
  - Otherwise, on the next edge: go to GRANT, `sel` := winner, `gnt` := 1<<winner, `cnt` := 0.
- GRANT:
  - `out_valid` = `req[sel]`.
  - `out_data` = lane `sel` of `in` when `out_valid`, else 0.
  - A transfer occurs when `out_valid` && `out_ready`. Each transfer increments `cnt`.
- Release condition, evaluated in GRANT, takes effect on the next edge:
  - `req[sel]` == 0, or
  - a transfer occurs with `cnt` == MAX_HOLD-1.
- On release:
  - `ptr` := `sel`+1 (mod 8).
  - Arbitrate on the current `req` with the search starting at `sel`+1. The released lane is last in priority but still eligible.
  - If a winner exists: stay in GRANT with the new `sel`/`gnt` and `cnt` := 0.
  - If no winner: go to IDLE, `gnt` := 0. `sel` holds its last value.
- `out_ready` low in GRANT: no transfer, `cnt` holds, grant holds indefinitely. Release can still occur if `req[sel]` drops.
- `out_src` always equals `sel`.

## Timing
- Reset (asynchronous assert; deassert is synchronous to `clk`):
  - State = IDLE.
  - `ptr` = 0, `sel` = 0, `gnt` = 0, `cnt` = 0, `busy` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0.
- `rst_n` asserted mid-burst aborts immediately. No transfer is counted in that cycle.
- Request latency: `req` rises in cycle t while IDLE → `gnt`/`sel`/`busy` valid in t+1. `out_valid` also rises in t+1 if `req` is still high.
- Grant switch: no bubble cycle. The cycle after the final transfer shows the new `gnt`, and `out_valid` follows the new lane.
- `out_valid`/`out_data` are combinational from registered `sel` and live `req`/`in`. There is no combinational path from `out_ready` to `out_valid`.
- Simultaneous final transfer and `req[sel]` drop: a single release; the transfer counts.
- Maximum wait for a persistent requester: 7 × MAX_HOLD transfers plus per-grant stall time.

## Test plan
- Reset: hold `req`=8'hFF with transfers active, pulse `rst_n` low mid-cycle → `gnt`=0, `out_valid`=0, `busy`=0 with no clock edge needed. After release, the first grant goes to lane 0.
- Single requester: MAX_HOLD=4, `req`=8'h04, `out_ready`=1 → `gnt`=8'h04 and `sel`=2 one cycle later. Exactly 4 transfers, then a release-and-regrant to lane 2 with no bubble. `out_valid` stays high throughout.
- Rotation: MAX_HOLD=1, `req`=8'hFF, `out_ready`=1 → `sel` sequence 0,1,2,...,7,0 with one transfer per cycle. `out_data` matches each lane's pattern (`in`=8'b1010_0110 gives 0,1,1,0,0,1,0,1).
- Backpressure: lane 5 granted, `out_ready`=0 for 10 cycles → `gnt` stays 8'h20, `cnt` frozen, `out_valid`=1. When ready returns, 4 transfers occur, then release.
- Early drop: `req`=8'h28, lane 3 granted, drop `req[3]` after 2 transfers → `out_valid`=0 that cycle, `gnt`=8'h20 on the next edge, and `ptr` becomes 4.
- Idle return: sole requester lane 7 drops → state goes to IDLE, `gnt`=0, `busy`=0, `sel` stays 7. The next `req`=8'h81 grants lane 0, since `ptr` wrapped from 7 to 0.
